// File: rtl/bsg_then_ready_link_round_robin_masked_pkg.sv
// Chip-level link constants and the lowest-set-bit helper shared by the masked
// round-robin link concentrator.
package bsg_then_ready_link_round_robin_masked_pkg;

  localparam int unsigned MaxLinks = 16;

  localparam int unsigned noc_num_links_gp = 4;
  localparam logic [MaxLinks-1:0] noc_link_default_mask_gp = 16'h000F;
  localparam int unsigned noc_link_burst_len_gp = 1;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int unsigned lowest_set_idx(input logic [MaxLinks-1:0] m);
    int unsigned idx;
    idx = 0;
    for (int i = MaxLinks - 1; i >= 0; i--) begin
      if (m[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bsg_then_ready_link_round_robin_masked_ptr.sv
// Masked round-robin pointer with burst counter; skips disabled links and
// resynchronises to the lowest enabled link on a mask load.
module bsg_link_masked_rr_ptr
  import bsg_then_ready_link_round_robin_masked_pkg::*;
#(
  parameter int unsigned num_in_p = 4,
  parameter int unsigned burst_len_p = 1,
  parameter logic [num_in_p-1:0] default_mask_p = '1,
  localparam int unsigned PtrW = $clog2(num_in_p)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [num_in_p-1:0] mask,
  input  logic                load,
  input  logic [num_in_p-1:0] load_mask,
  input  logic                advance,
  output logic [PtrW-1:0]     ptr
);

  localparam int unsigned CntW = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d, next_ptr;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            found;

  // Walk upward from the current index; modulo gives the wrap to the lowest bit.
  always_comb begin
    next_ptr = ptr_q;
    found    = 1'b0;
    for (int i = 1; i < int'(num_in_p); i++) begin
      if (!found && mask[(int'(ptr_q) + i) % int'(num_in_p)]) begin
        found    = 1'b1;
        next_ptr = PtrW'((int'(ptr_q) + i) % int'(num_in_p));
      end
    end
  end

  // A load wins over an advance in the same cycle.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load) begin
      ptr_d = PtrW'(lowest_set_idx(MaxLinks'(load_mask)));
      cnt_d = '0;
    end else if (advance) begin
      if (cnt_q == CntW'(burst_len_p - 1)) begin
        cnt_d = '0;
        ptr_d = next_ptr;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PtrW'(lowest_set_idx(MaxLinks'(default_mask_p)));
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) assert (mask[ptr_q]);
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/bsg_then_ready_link_round_robin_masked.sv
// Then-ready stream concentrator/reassembler over a maskable set of links,
// visiting enabled links in round-robin order with optional bursts.
module bsg_then_ready_link_round_robin_masked
  import bsg_then_ready_link_round_robin_masked_pkg::*;
#(
  parameter int unsigned width_p = 64,
  parameter int unsigned num_in_p = noc_num_links_gp,
  parameter int unsigned burst_len_p = noc_link_burst_len_gp,
  parameter logic [num_in_p-1:0] default_mask_p = '1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_in_p-1:0]           mask_i,
  input  logic                          mask_load_i,
  output logic [num_in_p-1:0]           mask_r_o,
  output logic                          mask_err_o,
  input  logic                          single_v_i,
  input  logic [width_p-1:0]            single_data_i,
  output logic                          single_yumi_o,
  output logic                          single_v_o,
  output logic [width_p-1:0]            single_data_o,
  input  logic                          single_yumi_i,
  output logic [num_in_p-1:0]           links_v_o,
  output logic [num_in_p*width_p-1:0]   links_data_o,
  input  logic [num_in_p-1:0]           links_yumi_i,
  input  logic [num_in_p-1:0]           links_v_i,
  input  logic [num_in_p*width_p-1:0]   links_data_i,
  output logic [num_in_p-1:0]           links_yumi_o,
  output logic [$clog2(num_in_p)-1:0]   tx_ptr_o,
  output logic [$clog2(num_in_p)-1:0]   rx_ptr_o
);

  localparam int unsigned PtrW = $clog2(num_in_p);

  logic [num_in_p-1:0] mask_q, mask_d;
  logic                mask_err_q, mask_err_d;
  logic                load_ok;
  logic [PtrW-1:0]     tx_ptr, rx_ptr;

  assign load_ok = mask_load_i && (mask_i != '0);

  always_comb begin
    mask_d     = load_ok ? mask_i : mask_q;
    mask_err_d = mask_err_q | (mask_load_i && (mask_i == '0));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_q     <= default_mask_p;
      mask_err_q <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      mask_err_q <= mask_err_d;
    end
  end

  bsg_link_masked_rr_ptr #(
    .num_in_p       (num_in_p),
    .burst_len_p    (burst_len_p),
    .default_mask_p (default_mask_p)
  ) u_tx_ptr (
    .clk       (clk_i),
    .reset_n   (reset_n_i),
    .mask      (mask_q),
    .load      (load_ok),
    .load_mask (mask_i),
    .advance   (single_yumi_o),
    .ptr       (tx_ptr)
  );

  bsg_link_masked_rr_ptr #(
    .num_in_p       (num_in_p),
    .burst_len_p    (burst_len_p),
    .default_mask_p (default_mask_p)
  ) u_rx_ptr (
    .clk       (clk_i),
    .reset_n   (reset_n_i),
    .mask      (mask_q),
    .load      (load_ok),
    .load_mask (mask_i),
    .advance   (single_yumi_i & reset_n_i),
    .ptr       (rx_ptr)
  );

  // Handshake outputs are gated by reset so they drop asynchronously.
  always_comb begin
    links_v_o    = '0;
    links_yumi_o = '0;
    if (reset_n_i) begin
      links_v_o[tx_ptr]    = single_v_i;
      links_yumi_o[rx_ptr] = single_yumi_i;
    end
    single_yumi_o = reset_n_i & links_yumi_i[tx_ptr];
    single_v_o    = reset_n_i & links_v_i[rx_ptr];
    single_data_o = links_data_i[rx_ptr*width_p +: width_p];
  end

  assign links_data_o = {num_in_p{single_data_i}};
  assign mask_r_o     = mask_q;
  assign mask_err_o   = mask_err_q;
  assign tx_ptr_o     = tx_ptr;
  assign rx_ptr_o     = rx_ptr;

endmodule

// File: tb/tb_bsg_then_ready_link_round_robin_masked.sv
// Scoreboard bench: stimulus queues expected (link, data) pairs, negedge monitors
// pop and compare on every transfer.
module tb_bsg_then_ready_link_round_robin_masked;

  typedef struct {
    int          link;
    logic [63:0] data;
  } exp_t;

  localparam logic [63:0] RxBase = 64'hBEEF_0000_0000_0000;

  logic clk;
  logic reset_n;

  // DUT A: 4 links, burst 1, width 64
  logic [3:0]   mask_i, mask_r_o, links_v_o, links_yumi_i, links_v_i, links_yumi_o;
  logic         mask_load_i, mask_err_o, single_v_i, single_yumi_o, single_v_o, single_yumi_i;
  logic [63:0]  single_data_i, single_data_o;
  logic [255:0] links_data_o, links_data_i;
  logic [1:0]   tx_ptr_o, rx_ptr_o;

  // DUT B: 4 links, burst 3, width 16
  logic [3:0]   b_mask_i, b_mask_r_o, b_links_v_o, b_links_yumi_i, b_links_yumi_o;
  logic         b_mask_load_i, b_mask_err_o, b_single_v_i, b_single_yumi_o, b_single_v_o;
  logic [15:0]  b_single_data_i, b_single_data_o;
  logic [63:0]  b_links_data_o;
  logic [1:0]   b_tx_ptr_o, b_rx_ptr_o;

  logic tx_ready, rx_ready;
  int   tests, fails;
  int   flit_id;
  exp_t exp_tx_a[$], exp_rx_a[$], exp_tx_b[$];
  exp_t me;

  assign links_yumi_i   = links_v_o & {4{tx_ready}};
  assign single_yumi_i  = single_v_o & rx_ready;
  assign b_links_yumi_i = b_links_v_o & {4{tx_ready}};

  bsg_then_ready_link_round_robin_masked #(
    .width_p (64), .num_in_p (4), .burst_len_p (1), .default_mask_p (4'hF)
  ) dut_a (
    .clk_i (clk), .reset_n_i (reset_n),
    .mask_i (mask_i), .mask_load_i (mask_load_i), .mask_r_o (mask_r_o), .mask_err_o (mask_err_o),
    .single_v_i (single_v_i), .single_data_i (single_data_i), .single_yumi_o (single_yumi_o),
    .single_v_o (single_v_o), .single_data_o (single_data_o), .single_yumi_i (single_yumi_i),
    .links_v_o (links_v_o), .links_data_o (links_data_o), .links_yumi_i (links_yumi_i),
    .links_v_i (links_v_i), .links_data_i (links_data_i), .links_yumi_o (links_yumi_o),
    .tx_ptr_o (tx_ptr_o), .rx_ptr_o (rx_ptr_o)
  );

  bsg_then_ready_link_round_robin_masked #(
    .width_p (16), .num_in_p (4), .burst_len_p (3), .default_mask_p (4'hF)
  ) dut_b (
    .clk_i (clk), .reset_n_i (reset_n),
    .mask_i (b_mask_i), .mask_load_i (b_mask_load_i), .mask_r_o (b_mask_r_o),
    .mask_err_o (b_mask_err_o),
    .single_v_i (b_single_v_i), .single_data_i (b_single_data_i),
    .single_yumi_o (b_single_yumi_o),
    .single_v_o (b_single_v_o), .single_data_o (b_single_data_o), .single_yumi_i (1'b0),
    .links_v_o (b_links_v_o), .links_data_o (b_links_data_o), .links_yumi_i (b_links_yumi_i),
    .links_v_i (4'b0), .links_data_i (64'b0), .links_yumi_o (b_links_yumi_o),
    .tx_ptr_o (b_tx_ptr_o), .rx_ptr_o (b_rx_ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: transfer with empty scoreboard at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (single_yumi_o) begin
      if (exp_tx_a.size() == 0) unexpected("a_tx");
      else begin
        me = exp_tx_a.pop_front();
        check("a_tx_link", 64'(links_v_o), 64'(1) << me.link);
        check("a_tx_data", links_data_o[me.link*64 +: 64], me.data);
      end
    end
    if (single_yumi_i) begin
      if (exp_rx_a.size() == 0) unexpected("a_rx");
      else begin
        me = exp_rx_a.pop_front();
        check("a_rx_yumi", 64'(links_yumi_o), 64'(1) << me.link);
        check("a_rx_data", single_data_o, me.data);
      end
    end
    if (b_single_yumi_o) begin
      if (exp_tx_b.size() == 0) unexpected("b_tx");
      else begin
        me = exp_tx_b.pop_front();
        check("b_tx_link", 64'(b_links_v_o), 64'(1) << me.link);
        check("b_tx_data", 64'(b_links_data_o[me.link*16 +: 16]), me.data);
      end
    end
  end

  // seq holds the expected link of flit k in nibble k.
  task automatic tx_run(input bit sel, input int n, input logic [31:0] seq);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.link = int'(seq[k*4 +: 4]);
      e.data = {32'hD0D0_0000, 32'(flit_id)};
      flit_id++;
      if (!sel) begin
        single_v_i    = 1'b1;
        single_data_i = e.data;
        exp_tx_a.push_back(e);
      end else begin
        b_single_v_i    = 1'b1;
        b_single_data_i = e.data[15:0];
        e.data          = {48'b0, e.data[15:0]};
        exp_tx_b.push_back(e);
      end
      @(posedge clk); #1;
    end
    single_v_i   = 1'b0;
    b_single_v_i = 1'b0;
  endtask

  task automatic rx_run(input int n, input logic [31:0] seq);
    rx_ready  = 1'b1;
    links_v_i = 4'hF;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.link = int'(seq[k*4 +: 4]);
      e.data = RxBase | 64'(e.link);
      exp_rx_a.push_back(e);
      @(posedge clk); #1;
    end
    rx_ready  = 1'b0;
    links_v_i = 4'h0;
  endtask

  task automatic load_a(input logic [3:0] m);
    mask_i      = m;
    mask_load_i = 1'b1;
    @(posedge clk); #1;
    mask_load_i = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; flit_id = 0;
    reset_n = 1'b0;
    mask_i = 4'h0; mask_load_i = 1'b0; b_mask_i = 4'h0; b_mask_load_i = 1'b0;
    single_data_i = '0; b_single_data_i = '0; b_single_v_i = 1'b0;
    for (int i = 0; i < 4; i++) links_data_i[i*64 +: 64] = RxBase | 64'(i);
    // Traffic presented during reset must not leak through.
    single_v_i = 1'b1; links_v_i = 4'hF; tx_ready = 1'b1; rx_ready = 1'b1;
    #12;
    check("rst_links_v", 64'(links_v_o), 64'h0);
    check("rst_single_v", 64'(single_v_o), 64'h0);
    check("rst_links_yumi", 64'(links_yumi_o), 64'h0);
    check("rst_single_yumi", 64'(single_yumi_o), 64'h0);
    single_v_i = 1'b0; links_v_i = 4'h0; rx_ready = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mask", 64'(mask_r_o), 64'hF);
    check("rst_tx_ptr", 64'(tx_ptr_o), 64'h0);
    check("rst_rx_ptr", 64'(rx_ptr_o), 64'h0);
    check("rst_err", 64'(mask_err_o), 64'h0);

    // Full mask, burst 1
    tx_run(0, 8, 32'h3210_3210);
    rx_run(8, 32'h3210_3210);

    // Mask 1010: only links 1 and 3, link 0 inbound valid is ignored
    load_a(4'hA);
    check("mA_mask", 64'(mask_r_o), 64'hA);
    check("mA_tx_ptr", 64'(tx_ptr_o), 64'h1);
    check("mA_rx_ptr", 64'(rx_ptr_o), 64'h1);
    tx_run(0, 4, 32'h3131);
    rx_run(4, 32'h3131);

    // Empty mask load is rejected and flagged
    load_a(4'h0);
    check("err_set", 64'(mask_err_o), 64'h1);
    check("err_mask_kept", 64'(mask_r_o), 64'hA);
    check("err_tx_ptr", 64'(tx_ptr_o), 64'h1);
    tx_run(0, 2, 32'h31);
    check("err_sticky", 64'(mask_err_o), 64'h1);

    // Load coincident with a transfer on link 2
    load_a(4'hF);
    tx_run(0, 2, 32'h10);
    check("co_tx_ptr", 64'(tx_ptr_o), 64'h2);
    begin
      exp_t e;
      e.link = 2;
      e.data = {32'hD0D0_0000, 32'(flit_id)};
      flit_id++;
      single_v_i = 1'b1; single_data_i = e.data;
      mask_i = 4'hC; mask_load_i = 1'b1;
      exp_tx_a.push_back(e);
      @(posedge clk); #1;
      mask_load_i = 1'b0;
    end
    tx_run(0, 3, 32'h232);
    check("co_mask", 64'(mask_r_o), 64'hC);
    check("co_tx_ptr_end", 64'(tx_ptr_o), 64'h3);
    check("co_rx_ptr", 64'(rx_ptr_o), 64'h2);

    // DUT B: burst 3 on mask 0111 with a stall mid-burst
    b_mask_i = 4'h7; b_mask_load_i = 1'b1;
    @(posedge clk); #1;
    b_mask_load_i = 1'b0;
    check("b_mask", 64'(b_mask_r_o), 64'h7);
    check("b_ptr0", 64'(b_tx_ptr_o), 64'h0);
    tx_run(1, 2, 32'h00);
    repeat (5) @(posedge clk);
    #1;
    check("b_ptr_stall", 64'(b_tx_ptr_o), 64'h0);
    tx_run(1, 5, 32'h21110);
    check("b_ptr_end", 64'(b_tx_ptr_o), 64'h2);

    // Asynchronous reset with traffic pending
    tx_ready = 1'b0; rx_ready = 1'b0;
    single_v_i = 1'b1; links_v_i = 4'hF;
    #1;
    check("pre_rst_links_v", 64'(links_v_o), 64'h8);
    check("pre_rst_single_v", 64'(single_v_o), 64'h1);
    #1;
    reset_n = 1'b0; tx_ready = 1'b1; rx_ready = 1'b1;
    #1;
    check("arst_links_v", 64'(links_v_o), 64'h0);
    check("arst_single_v", 64'(single_v_o), 64'h0);
    check("arst_links_yumi", 64'(links_yumi_o), 64'h0);
    check("arst_single_yumi", 64'(single_yumi_o), 64'h0);
    single_v_i = 1'b0; links_v_i = 4'h0; rx_ready = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_mask", 64'(mask_r_o), 64'hF);
    check("post_rst_tx_ptr", 64'(tx_ptr_o), 64'h0);
    check("post_rst_rx_ptr", 64'(rx_ptr_o), 64'h0);
    check("post_rst_err", 64'(mask_err_o), 64'h0);
    check("b_post_rst_mask", 64'(b_mask_r_o), 64'hF);

    repeat (2) @(posedge clk);
    #1;
    check("a_tx_drained", 64'(exp_tx_a.size()), 64'h0);
    check("a_rx_drained", 64'(exp_rx_a.size()), 64'h0);
    check("b_tx_drained", 64'(exp_tx_b.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
